capture_readout: RTL and testbench
==================================

# capture_readout

Capture controller and readout stage for the internal logic analyzer sample buffer. It drives `write_enable` into the circular sample memory writer and watches its `waddr`/`primed` status. On a trigger it records a fixed number of post-trigger samples and then freezes the buffer. It then streams the whole captured window out oldest-first over a valid/ready interface to the host-link serializer.

## Interface
- `DATA_WIDTH`, default 8: sample width; must match the memory writer.
- `ADDR_WIDTH`, default 4: buffer address width; buffer depth is 2^ADDR_WIDTH.
- `POST_TRIGGER`, default 4: samples written after the trigger sample; legal range 0 .. 2^ADDR_WIDTH-1.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high; also applied to the memory writer.
- `arm`  in  1  single-cycle pulse that starts a capture from IDLE or DONE; ignored in other states.
- `trigger`  in  1  trigger condition from the trigger unit.
- `waddr`  in  ADDR_WIDTH  writer's next write address.
- `primed`  in  1  writer's buffer-fully-written flag.
- `write_enable`  out  1  sample write strobe to the writer.
- `raddr`  out  ADDR_WIDTH  read address into the sample memory.
- `rdata`  in  DATA_WIDTH  `memory[raddr]`, combinational, same cycle.
- `out_data`  out  DATA_WIDTH  registered sample to the host link.
- `out_valid`  out  1  `out_data` holds a sample.
- `out_ready`  in  1  consumer accepts the sample this cycle.
- `busy`  out  1  high in every state except IDLE and DONE.
- `done`  out  1  high in DONE only.

## Operation
- States: IDLE → ARMED → POST → LOAD → STREAM → DONE.
- IDLE: `write_enable`=0. On `arm`, go to ARMED.
- ARMED:
  - `write_enable`=1.
  - On a trigger hit, the current cycle's sample is the trigger sample and is written.
  - If POST_TRIGGER=0, go to LOAD; otherwise load the post counter with POST_TRIGGER and go to POST.
- POST:
  - `write_enable`=1 and the counter decrements each cycle.
  - When the counter reads 1, go to LOAD, so exactly POST_TRIGGER writes happen in POST.
- LOAD:
  - `write_enable`=0, so `waddr`/`primed` are frozen and final.
  - If `primed`=1: start address = `waddr`, remaining = 2^ADDR_WIDTH.
  - If `primed`=0: start address = 0, remaining = `waddr`.
  - `raddr` takes the start address. Go to STREAM, or to DONE if remaining=0.
  - The remaining counter is ADDR_WIDTH+1 bits wide.
- STREAM:
  - Output register loads when `!out_valid || out_ready`: `out_data`←`rdata`, `out_valid`←1.
  - On each load, `raddr` increments modulo 2^ADDR_WIDTH and remaining decrements.
  - When remaining hits 0 and the last sample is accepted (`out_valid && out_ready`), `out_valid`←0 and go to DONE.
- DONE: `write_enable`=0 and the buffer contents are retained. `arm` re-enters ARMED.
- `arm` in DONE does not reset the writer. A new capture continues from the frozen `waddr`, and `primed` stays set.
- `write_enable` is a combinational decode of the state (ARMED or POST).
- Reset values: state IDLE; `write_enable`, `out_valid`, `busy`, `done` = 0; `raddr`, `out_data`, counters = 0.

## Timing
- `arm` pulse at edge N gives ARMED and `write_enable`=1 from cycle N+1.
- Trigger hit in cycle T (in ARMED): writes occur in cycles T .. T+POST_TRIGGER, and LOAD is cycle T+POST_TRIGGER+1.
- First `out_valid` comes the cycle after the first STREAM cycle. With `out_ready` held high, throughput is one sample per cycle.
- While `out_valid && !out_ready`, `out_data` and `raddr` hold stable.
- Reset in any state (including mid-STREAM) returns to IDLE with `out_valid`=0 in the next cycle, and any pending sample is dropped.
- `trigger` outside ARMED is ignored.
- `arm` and `trigger` in the same cycle from IDLE: only `arm` acts, and the trigger is evaluated from ARMED onward.

## Configuration
- `CAPTURE_TRIGGER_EDGE_EN` defined:
  - A trigger hit is a rising edge of `trigger`: registered previous value low, current value high.
  - The edge register updates every cycle and resets to 0.
  - A level already high at arm time does not fire until it falls and rises again.
- Not defined: a trigger hit is `trigger`=1 in any ARMED cycle (level-sensitive), and there is no edge register.

## Test plan
All scenarios use DATA_WIDTH=8, ADDR_WIDTH=4, POST_TRIGGER=4, with the writer fed an incrementing sample 0,1,2,… per written cycle.
- Reset behaviour: assert `reset` 2 cycles → `write_enable`, `out_valid`, `busy`, `done`, `raddr`, `out_data` all 0.
- Primed capture: `arm`, trigger on the 30th written sample (value 29) → exactly 16 samples out, values 18..33 in order, then `done`=1.
- Unprimed capture: trigger on sample value 2 → `waddr`=7 and `primed`=0 at LOAD → 7 samples out, 0..6, then `done`.
- Backpressure: hold `out_ready` low for 3 cycles mid-stream → `out_data` unchanged across the stall; full sequence complete, no duplicates or drops.
- Reset mid-STREAM after 5 samples → next cycle `out_valid`=0, state IDLE; a new `arm` restarts correctly.
- Trigger mode: `trigger` held high before `arm`.
  - Without `CAPTURE_TRIGGER_EDGE_EN`: capture fires in the first ARMED cycle.
  - With it defined: no trigger until `trigger` drops low and rises again.

Source files
------------

// File: rtl/capture_readout_if.sv
// capture_readout_if: valid/ready sample stream from the capture readout
// stage to the host-link serializer. The readout stage drives the master side.
interface capture_readout_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/capture_readout.sv
// capture_readout: logic analyzer capture controller and readout stage.
// Enables the circular sample writer while armed, records POST_TRIGGER
// samples after a trigger hit, freezes the buffer, then streams the captured
// window oldest-first over the valid/ready stream interface.
// Optional build macro CAPTURE_TRIGGER_EDGE_EN: when defined a trigger hit is a
// rising edge of 'trigger'; otherwise 'trigger' is level-sensitive.
module capture_readout #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 4,
  parameter int POST_TRIGGER = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  arm,
  input  logic                  trigger,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic                  primed,
  output logic                  write_enable,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] rdata,
  capture_readout_if.master     stream,
  output logic                  busy,
  output logic                  done
);

  localparam int                  DEPTH      = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] POST_LOAD = ADDR_WIDTH'(POST_TRIGGER);
  localparam bit                  NO_POST    = (POST_TRIGGER == 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    POST   = 3'd2,
    LOAD   = 3'd3,
    STREAM = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] post_cnt;
  logic [ADDR_WIDTH:0]   remaining;
  logic                  trig_hit;
  logic                  stream_load;
  logic                  last_accept;
  logic [ADDR_WIDTH-1:0] load_start;
  logic [ADDR_WIDTH:0]   load_remaining;

`ifdef CAPTURE_TRIGGER_EDGE_EN
  logic trigger_q;

  // Previous trigger level, so a level already high at arm time cannot fire
  always_ff @(posedge clk) begin
    if (reset) trigger_q <= 1'b0;
    else       trigger_q <= trigger;
  end

  assign trig_hit = trigger && !trigger_q;
`else
  assign trig_hit = trigger;
`endif

  // Once the writer is frozen a full buffer starts at the oldest slot (waddr),
  // a partial one starts at 0 and holds waddr samples
  assign load_start     = primed ? waddr : '0;
  assign load_remaining = primed ? FULL_COUNT : {1'b0, waddr};

  assign stream_load = !stream.out_valid || stream.out_ready;
  assign last_accept = (remaining == '0) && stream.out_valid && stream.out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode plus the state-decoded strobes and status flags
  always_comb begin
    state_next   = state;
    write_enable = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (arm) state_next = ARMED;
      end
      ARMED: begin
        write_enable = 1'b1;
        if (trig_hit) state_next = NO_POST ? LOAD : POST;
      end
      POST: begin
        write_enable = 1'b1;
        if (post_cnt == ADDR_WIDTH'(1)) state_next = LOAD;
      end
      LOAD: begin
        state_next = (load_remaining == '0) ? DONE : STREAM;
      end
      STREAM: begin
        if (last_accept) state_next = DONE;
      end
      DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (arm) state_next = ARMED;
      end
      default: state_next = IDLE;
    endcase
  end

  // Post-trigger counter, read pointer, remaining count and output register
  always_ff @(posedge clk) begin
    if (reset) begin
      post_cnt         <= '0;
      remaining        <= '0;
      raddr            <= '0;
      stream.out_data  <= '0;
      stream.out_valid <= 1'b0;
    end else begin
      case (state)
        ARMED: begin
          if (trig_hit) post_cnt <= POST_LOAD;
        end
        POST: begin
          post_cnt <= post_cnt - 1'b1;
        end
        LOAD: begin
          raddr     <= load_start;
          remaining <= load_remaining;
        end
        STREAM: begin
          if (remaining != '0) begin
            if (stream_load) begin
              stream.out_data  <= rdata;
              stream.out_valid <= 1'b1;
              raddr            <= raddr + 1'b1;
              remaining        <= remaining - 1'b1;
            end
          end else if (last_accept) begin
            stream.out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_capture_readout.sv
// tb_capture_readout: self-checking bench for capture_readout. Models the
// circular sample writer (incrementing sample per written cycle) and memory,
// and scores the streamed window against expectations queued at trigger time.
module tb_capture_readout;

  localparam int DW   = 8;
  localparam int AW   = 4;
  localparam int PT   = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          arm;
  logic          trigger;
  logic [AW-1:0] waddr;
  logic          primed;
  logic          write_enable;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata;
  logic          busy;
  logic          done;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] sample_cnt;

  int vectors = 0;
  int miscompares = 0;
  logic [DW-1:0] exp_q [$];

  capture_readout_if #(.DATA_WIDTH(DW)) bus ();

  capture_readout #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .POST_TRIGGER(PT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .arm         (arm),
    .trigger     (trigger),
    .waddr       (waddr),
    .primed      (primed),
    .write_enable(write_enable),
    .raddr       (raddr),
    .rdata       (rdata),
    .stream      (bus.master),
    .busy        (busy),
    .done        (done)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Circular sample writer model: one incrementing sample per enabled cycle
  always @(posedge clk) begin
    if (reset) begin
      waddr      <= '0;
      primed     <= 1'b0;
      sample_cnt <= '0;
    end else if (write_enable) begin
      mem[waddr] <= sample_cnt;
      sample_cnt <= sample_cnt + 1'b1;
      waddr      <= waddr + 1'b1;
      if (waddr == AW'(DEPTH - 1)) primed <= 1'b1;
    end
  end

  assign rdata = mem[raddr];

  task automatic do_reset;
    reset         = 1'b1;
    arm           = 1'b0;
    trigger       = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic pulse_arm;
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  // Queue the expected window: the last min(total, DEPTH) samples written,
  // where the trigger sample is followed by PT more and counting began at 0
  task automatic push_window(input int trig_val);
    int total, last, n;
    total = trig_val + PT + 1;
    last  = trig_val + PT;
    n     = (total > DEPTH) ? DEPTH : total;
    for (int i = 0; i < n; i++) exp_q.push_back(DW'(last - n + 1 + i));
  endtask

  task automatic fire_at(input int val);
    int cyc;
    cyc = 0;
    while (int'(sample_cnt) != val && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (int'(sample_cnt) != val) begin
      miscompares++;
      $display("[TB] FAIL fire_wait: sample count %0d, required %0d", sample_cnt, val);
    end
    trigger = 1'b1;
    push_window(val);
    @(negedge clk);
    trigger = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    reset = 1'b1;
    @(negedge clk);
    vectors += 6;
    if (write_enable !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_we: got %b need 0", write_enable); end
    if (bus.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid: got %b need 0", bus.out_valid); end
    if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b need 0", busy); end
    if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %b need 0", done); end
    if (raddr !== '0) begin miscompares++; $display("[TB] FAIL reset_raddr: got %0d need 0", raddr); end
    if (bus.out_data !== '0) begin miscompares++; $display("[TB] FAIL reset_data: got %0d need 0", bus.out_data); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_primed_capture;
    int got;
    logic [DW-1:0] e;
    got = 0;
    do_reset();
    pulse_arm();
    vectors++;
    if (write_enable !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL arm_we: we=%b busy=%b need 1/1", write_enable, busy);
    end
    fire_at(29);
    for (int cyc = 0; cyc < 200 && done !== 1'b1; cyc++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        vectors++;
        got++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL primed_extra: got %0d, none expected", bus.out_data);
        end else begin
          e = exp_q.pop_front();
          if (bus.out_data !== e) begin miscompares++; $display("[TB] FAIL primed_data: got %0d need %0d", bus.out_data, e); end
        end
      end
    end
    vectors += 2;
    if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL primed_done: got %b need 1", done); end
    if (got !== 16) begin miscompares++; $display("[TB] FAIL primed_count: got %0d need 16", got); end
  endtask

  task automatic test_unprimed_capture;
    int got;
    logic [DW-1:0] e;
    got = 0;
    do_reset();
    pulse_arm();
    fire_at(2);
    for (int cyc = 0; cyc < 200 && done !== 1'b1; cyc++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        vectors++;
        got++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL unprimed_extra: got %0d, none expected", bus.out_data);
        end else begin
          e = exp_q.pop_front();
          if (bus.out_data !== e) begin miscompares++; $display("[TB] FAIL unprimed_data: got %0d need %0d", bus.out_data, e); end
        end
      end
    end
    vectors += 3;
    if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL unprimed_done: got %b need 1", done); end
    if (got !== 7) begin miscompares++; $display("[TB] FAIL unprimed_count: got %0d need 7", got); end
    if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL unprimed_busy: got %b need 0", busy); end
  endtask

  task automatic test_back_pressure;
    int got, stall;
    logic [DW-1:0] e, held_d;
    logic [AW-1:0] held_a;
    got = 0;
    stall = 0;
    held_d = '0;
    held_a = '0;
    do_reset();
    pulse_arm();
    fire_at(20);
    for (int cyc = 0; cyc < 200 && done !== 1'b1; cyc++) begin
      @(negedge clk);
      if (got == 6 && stall < 3) begin
        bus.out_ready = 1'b0;
        if (stall == 0) begin
          held_d = bus.out_data;
          held_a = raddr;
        end else begin
          vectors++;
          if (bus.out_data !== held_d || raddr !== held_a) begin
            miscompares++;
            $display("[TB] FAIL stall_hold: data %0d addr %0d, need %0d addr %0d", bus.out_data, raddr, held_d, held_a);
          end
        end
        stall++;
      end else begin
        bus.out_ready = 1'b1;
      end
      if (bus.out_valid && bus.out_ready) begin
        vectors++;
        got++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL bp_extra: got %0d, none expected", bus.out_data);
        end else begin
          e = exp_q.pop_front();
          if (bus.out_data !== e) begin miscompares++; $display("[TB] FAIL bp_data: got %0d need %0d", bus.out_data, e); end
        end
      end
    end
    bus.out_ready = 1'b1;
    vectors += 2;
    if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_done: got %b need 1", done); end
    if (got !== 16) begin miscompares++; $display("[TB] FAIL bp_count: got %0d need 16", got); end
  endtask

  task automatic test_reset_mid_stream;
    int got;
    logic [DW-1:0] e;
    got = 0;
    do_reset();
    pulse_arm();
    fire_at(29);
    for (int cyc = 0; cyc < 200 && got < 5; cyc++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        got++;
        vectors++;
        e = exp_q.pop_front();
        if (bus.out_data !== e) begin miscompares++; $display("[TB] FAIL midrst_data: got %0d need %0d", bus.out_data, e); end
      end
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vectors += 3;
    if (bus.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_valid: got %b need 0", bus.out_valid); end
    if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_idle: busy %b done %b need 0/0", busy, done); end
    if (got !== 5) begin miscompares++; $display("[TB] FAIL midrst_pre: got %0d need 5", got); end
    exp_q.delete();
    got = 0;
    pulse_arm();
    fire_at(2);
    for (int cyc = 0; cyc < 200 && done !== 1'b1; cyc++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        vectors++;
        got++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL restart_extra: got %0d, none expected", bus.out_data);
        end else begin
          e = exp_q.pop_front();
          if (bus.out_data !== e) begin miscompares++; $display("[TB] FAIL restart_data: got %0d need %0d", bus.out_data, e); end
        end
      end
    end
    vectors += 2;
    if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL restart_done: got %b need 1", done); end
    if (got !== 7) begin miscompares++; $display("[TB] FAIL restart_count: got %0d need 7", got); end
  endtask

  task automatic test_trigger_mode;
    int got;
    logic [DW-1:0] e;
    got = 0;
    do_reset();
    trigger = 1'b1;
`ifdef CAPTURE_TRIGGER_EDGE_EN
    pulse_arm();
    repeat (8) @(negedge clk);
    vectors++;
    if (write_enable !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL edge_hold: we=%b busy=%b need 1/1", write_enable, busy);
    end
    trigger = 1'b0;
    @(negedge clk);
    trigger = 1'b1;
    push_window(int'(sample_cnt));
    @(negedge clk);
    trigger = 1'b0;
`else
    push_window(0);
    pulse_arm();
`endif
    for (int cyc = 0; cyc < 200 && done !== 1'b1; cyc++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        vectors++;
        got++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL trig_extra: got %0d, none expected", bus.out_data);
        end else begin
          e = exp_q.pop_front();
          if (bus.out_data !== e) begin miscompares++; $display("[TB] FAIL trig_data: got %0d need %0d", bus.out_data, e); end
        end
      end
    end
    trigger = 1'b0;
    vectors += 2;
    if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL trig_done: got %b need 1", done); end
    if (exp_q.size() !== 0) begin miscompares++; $display("[TB] FAIL trig_left: %0d samples missing, need 0", exp_q.size()); end
  endtask

  initial begin
    $display("[TB] capture_readout bench start");
    test_reset();
    test_primed_capture();
    test_unprimed_capture();
    test_back_pressure();
    test_reset_mid_stream();
    test_trigger_mode();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
